face_result_packetizer: RTL



---
 rtl/face_pkt_pkg.sv | 50 +++++
 rtl/face_result_packetizer_sync_fifo.sv | 46 ++++
 rtl/face_result_packetizer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/face_pkt_pkg.sv
// Shared types and constants for the face-result packetizer.
// Packet framing, FSM states and the buffered entry layout.
package face_pkt_pkg;

    localparam logic [7:0] HDR_FACE = 8'hA5;
    localparam logic [7:0] HDR_EOF  = 8'h5A;

    localparam int FACE_PKT_LEN = 7;
    localparam int EOF_PKT_LEN  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SEND,
        S_WAIT_TX
    } state_t;

    typedef struct packed {
        logic        is_eof;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale_or_count;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Byte 0 is transmitted first.
    typedef logic [FACE_PKT_LEN-1:0][7:0] pkt_t;

    function automatic pkt_t build_pkt(entry_t e);
        pkt_t p;
        p = '0;
        if (e.is_eof) begin
            p[0] = HDR_EOF;
            p[1] = e.scale_or_count;
            p[2] = e.scale_or_count;
        end else begin
            p[0] = HDR_FACE;
            p[1] = e.x[15:8];
            p[2] = e.x[7:0];
            p[3] = e.y[15:8];
            p[4] = e.y[7:0];
            p[5] = e.scale_or_count;
            p[6] = p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
        end
        return p;
    endfunction

endpackage

// File: rtl/face_result_packetizer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Pointers carry one extra wrap bit to separate full from empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_wr;
    logic         do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/face_result_packetizer.sv
// Buffers face results and end-of-frame markers, then serialises
// each one into a byte packet for the UART transmitter.
module face_result_packetizer
    import face_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           face_valid,
    input  logic [X_W-1:0] face_x,
    input  logic [Y_W-1:0] face_y,
    input  logic [7:0]     face_scale,
    output logic           face_ready,
    input  logic           frame_done,
    output logic [7:0]     uart_data,
    output logic           send_uart_data,
    input  logic           uart_data_sent,
    output logic           busy
);

    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;
    entry_t wr_ent;
    entry_t rd_ent;

    logic       eof_pend_q, eof_pend_d;
    logic [7:0] count_q, count_d;
    logic       face_acc;
    logic       eof_push;

    state_t     state_q;
    entry_t     ent_q;
    pkt_t       pkt_q;
    pkt_t       pkt_w;
    logic [2:0] idx_q;
    logic [2:0] last_q;
    logic [7:0] data_q;
    logic       send_q;

    // A pending EOF blocks new faces so it cannot be overtaken.
    assign face_ready = !reset && !fifo_full && !eof_pend_q;
    assign face_acc   = face_valid && face_ready;
    assign eof_push   = eof_pend_q && !fifo_full;
    assign fifo_push  = face_acc || eof_push;
    assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;

    always_comb begin
        wr_ent = '0;
        if (eof_push) begin
            wr_ent.is_eof         = 1'b1;
            wr_ent.scale_or_count = count_q;
        end else begin
            wr_ent.x              = 16'(face_x);
            wr_ent.y              = 16'(face_y);
            wr_ent.scale_or_count = face_scale;
        end
    end

    always_comb begin
        count_d    = count_q;
        eof_pend_d = eof_pend_q;
        if (eof_push) begin
            count_d    = '0;
            eof_pend_d = 1'b0;
        end else begin
            if (face_acc && count_q != 8'hFF) count_d = count_q + 8'd1;
            if (frame_done) eof_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            eof_pend_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            eof_pend_q <= eof_pend_d;
        end
    end

    sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (fifo_push),
        .wr_data_i (wr_ent),
        .rd_en_i   (fifo_pop),
        .rd_data_o (rd_ent),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign pkt_w = build_pkt(ent_q);

    // uart_data is loaded on entry to SETUP so it leads the send pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ent_q   <= '0;
            pkt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        ent_q   <= rd_ent;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pkt_q   <= pkt_w;
                    data_q  <= pkt_w[0];
                    idx_q   <= '0;
                    last_q  <= ent_q.is_eof ? 3'(EOF_PKT_LEN - 1)
                                            : 3'(FACE_PKT_LEN - 1);
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    data_q  <= pkt_q[idx_q];
                    send_q  <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    send_q  <= 1'b0;
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (uart_data_sent) begin
                        if (idx_q == last_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            data_q  <= pkt_q[idx_q + 3'd1];
                            state_q <= S_SETUP;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_data      = data_q;
    assign send_uart_data = send_q;
    assign busy           = !fifo_empty || (state_q != S_IDLE) || eof_pend_q;

endmodule
